// File: rtl/dm_sb_pkg.sv
// rtl/dm_sb_pkg.sv - shared types and helpers for the DM store buffer
package dm_sb_pkg;

  localparam logic [3:0] BE_WORD = 4'hF;

  typedef struct packed {
    logic        valid;
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } sb_entry_t;

  function automatic int SB_PTR_W(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dm_sb_match.sv
// rtl/dm_sb_match.sv - load address lookup against pending stores
// Walks back from the tail so the first valid match found is the youngest one.
module dm_sb_match
  import dm_sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = SB_PTR_W(DEPTH)
) (
  input  logic [DEPTH-1:0] ent_valid,
  input  logic [29:0]      ent_waddr [DEPTH],
  input  logic [31:0]      ent_data  [DEPTH],
  input  logic [3:0]       ent_be    [DEPTH],
  input  logic [PW-1:0]    tail,
  input  logic [29:0]      lk_waddr,
  output logic             hit_any,
  output logic             hit_full,
  output logic [31:0]      sel_data
);

  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit_any  = 1'b0;
    hit_full = 1'b0;
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PW'(i + 1);
      if (!hit_any && ent_valid[idx] && (ent_waddr[idx] == lk_waddr)) begin
        hit_any  = 1'b1;
        hit_full = (ent_be[idx] == BE_WORD);
        sel_data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - posted-write store buffer draining into data memory
// FIFO storage, pointers, occupancy count and drain; lookups go through dm_sb_match.
module dm_store_buffer
  import dm_sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        St_Valid,
  input  logic [31:0] St_Addr,
  input  logic [31:0] St_WD,
  input  logic [3:0]  St_BE,
  input  logic [31:0] St_PC,
  output logic        St_Ready,
  input  logic        Ld_Valid,
  input  logic [31:0] Ld_Addr,
  output logic        Ld_Hit,
  output logic [31:0] Ld_Data,
  output logic        Ld_Stall,
  output logic        DM_Wr,
  output logic [31:0] DM_A,
  output logic [31:0] DM_WD,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_PC,
  input  logic        DM_Busy,
  output logic        Empty
);

  localparam int PW = SB_PTR_W(DEPTH);

  sb_entry_t     mem_q [DEPTH];
  sb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic push, pop;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{St_Addr[1:0], Ld_Addr[1:0]};

  assign Empty    = (count_q == '0);
  assign St_Ready = (count_q != (PW + 1)'(DEPTH));
  assign DM_Wr    = !Empty && !DM_Busy;
  assign push     = St_Valid && St_Ready;
  assign pop      = DM_Wr;

  assign DM_A  = Empty ? 32'h0 : {mem_q[head_q].waddr, 2'b00};
  assign DM_WD = Empty ? 32'h0 : mem_q[head_q].data;
  assign DM_BE = Empty ? 4'h0  : mem_q[head_q].be;
  assign DM_PC = Empty ? 32'h0 : mem_q[head_q].pc;

  // push only when not full and pop only when not empty, so they never hit the same slot
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      mem_d[head_q].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (push) begin
      mem_d[tail_q] = '{valid: 1'b1, waddr: St_Addr[31:2], data: St_WD,
                        be: St_BE, pc: St_PC};
      tail_d = tail_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  logic [DEPTH-1:0] ent_valid;
  logic [29:0]      ent_waddr [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [3:0]       ent_be    [DEPTH];
  logic             hit_any, hit_full;
  logic [31:0]      sel_data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = mem_q[i].valid;
      ent_waddr[i] = mem_q[i].waddr;
      ent_data[i]  = mem_q[i].data;
      ent_be[i]    = mem_q[i].be;
    end
  end

  dm_sb_match #(.DEPTH(DEPTH), .PW(PW)) u_match (
    .ent_valid (ent_valid),
    .ent_waddr (ent_waddr),
    .ent_data  (ent_data),
    .ent_be    (ent_be),
    .tail      (tail_q),
    .lk_waddr  (Ld_Addr[31:2]),
    .hit_any   (hit_any),
    .hit_full  (hit_full),
    .sel_data  (sel_data)
  );

  assign Ld_Hit   = Ld_Valid && hit_full;
  assign Ld_Stall = Ld_Valid && hit_any && !hit_full;
  assign Ld_Data  = Ld_Hit ? sel_data : 32'h0;

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - directed self-checking bench for dm_store_buffer
module tb_dm_store_buffer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        St_Valid;
  logic [31:0] St_Addr, St_WD, St_PC;
  logic [3:0]  St_BE;
  logic        St_Ready;
  logic        Ld_Valid;
  logic [31:0] Ld_Addr;
  logic        Ld_Hit, Ld_Stall;
  logic [31:0] Ld_Data;
  logic        DM_Wr;
  logic [31:0] DM_A, DM_WD, DM_PC;
  logic [3:0]  DM_BE;
  logic        DM_Busy;
  logic        Empty;

  int tests = 0;
  int fails = 0;

  dm_store_buffer #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .St_Valid(St_Valid), .St_Addr(St_Addr), .St_WD(St_WD), .St_BE(St_BE),
    .St_PC(St_PC), .St_Ready(St_Ready),
    .Ld_Valid(Ld_Valid), .Ld_Addr(Ld_Addr), .Ld_Hit(Ld_Hit), .Ld_Data(Ld_Data),
    .Ld_Stall(Ld_Stall),
    .DM_Wr(DM_Wr), .DM_A(DM_A), .DM_WD(DM_WD), .DM_BE(DM_BE), .DM_PC(DM_PC),
    .DM_Busy(DM_Busy), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] pc);
    St_Valid = 1'b1; St_Addr = a; St_WD = wd; St_BE = be; St_PC = pc;
    tick();
    St_Valid = 1'b0;
    #1;
  endtask

  initial begin
    Reset = 1'b0; St_Valid = 1'b0; St_Addr = '0; St_WD = '0; St_BE = '0; St_PC = '0;
    Ld_Valid = 1'b0; Ld_Addr = '0; DM_Busy = 1'b0;
    #2;
    chk("rst_st_ready", St_Ready, 1);
    chk("rst_empty", Empty, 1);
    chk("rst_dm_wr", DM_Wr, 0);
    chk("rst_dm_a", DM_A, 0);
    chk("rst_ld_hit", Ld_Hit, 0);
    chk("rst_ld_stall", Ld_Stall, 0);
    tick();
    Reset = 1'b1;
    #1;

    // single store drains the cycle after it is accepted
    St_Valid = 1'b1; St_Addr = 32'h10; St_WD = 32'hDEADBEEF; St_BE = 4'hF; St_PC = 32'h3000;
    #1;
    chk("s1_ready", St_Ready, 1);
    chk("s1_no_bypass", DM_Wr, 0);
    tick();
    St_Valid = 1'b0;
    #1;
    chk("s1_dm_wr", DM_Wr, 1);
    chk("s1_dm_a", DM_A, 32'h10);
    chk("s1_dm_wd", DM_WD, 32'hDEADBEEF);
    chk("s1_dm_be", DM_BE, 4'hF);
    chk("s1_dm_pc", DM_PC, 32'h3000);
    tick();
    chk("s1_empty", Empty, 1);
    chk("s1_dm_wr_off", DM_Wr, 0);
    chk("s1_dm_a_zero", DM_A, 0);

    // fill with DM busy; pointers start at 1 so the fill wraps
    DM_Busy = 1'b1;
    for (int i = 0; i < 4; i++)
      do_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 32'h4000 + 32'(4 * i));
    chk("full_ready", St_Ready, 0);
    chk("full_empty", Empty, 0);
    chk("full_busy_nowr", DM_Wr, 0);
    St_Valid = 1'b1; St_Addr = 32'h200; St_WD = 32'h55; St_BE = 4'hF; St_PC = 32'h6000;
    DM_Busy = 1'b0;
    #1;
    chk("full_drain_ready", St_Ready, 0);
    chk("full_drain_wr", DM_Wr, 1);
    chk("drain0_a", DM_A, 32'h100);
    chk("drain0_wd", DM_WD, 32'hA0);
    chk("drain0_pc", DM_PC, 32'h4000);
    tick();
    St_Valid = 1'b0;
    #1;
    chk("after_drain_ready", St_Ready, 1);
    chk("drain1_a", DM_A, 32'h104);
    chk("drain1_wd", DM_WD, 32'hA1);
    chk("drain1_pc", DM_PC, 32'h4004);
    tick();
    chk("drain2_a", DM_A, 32'h108);
    chk("drain2_wd", DM_WD, 32'hA2);
    tick();
    chk("drain3_a", DM_A, 32'h10C);
    chk("drain3_wd", DM_WD, 32'hA3);
    chk("drain3_wr", DM_Wr, 1);
    tick();
    chk("fifth_rejected_empty", Empty, 1);
    chk("fifth_rejected_nowr", DM_Wr, 0);

    // youngest full-word match is forwarded
    DM_Busy = 1'b1;
    do_store(32'h20, 32'h11111111, 4'hF, 32'h7000);
    do_store(32'h20, 32'h22222222, 4'hF, 32'h7004);
    Ld_Valid = 1'b1; Ld_Addr = 32'h23;
    #1;
    chk("fwd_hit", Ld_Hit, 1);
    chk("fwd_data", Ld_Data, 32'h22222222);
    chk("fwd_stall", Ld_Stall, 0);
    Ld_Addr = 32'h24;
    #1;
    chk("miss_hit", Ld_Hit, 0);
    chk("miss_stall", Ld_Stall, 0);
    chk("miss_data", Ld_Data, 0);
    Ld_Valid = 1'b0; Ld_Addr = 32'h20;
    #1;
    chk("noload_hit", Ld_Hit, 0);
    chk("noload_data", Ld_Data, 0);
    DM_Busy = 1'b0;
    tick();
    tick();
    chk("fwd_drained", Empty, 1);

    // partial store stalls the load until it drains
    DM_Busy = 1'b1;
    do_store(32'h40, 32'hAA, 4'b0001, 32'h5000);
    Ld_Valid = 1'b1; Ld_Addr = 32'h40; DM_Busy = 1'b0;
    #1;
    chk("part_stall", Ld_Stall, 1);
    chk("part_hit", Ld_Hit, 0);
    chk("part_drain_wr", DM_Wr, 1);
    chk("part_drain_be", DM_BE, 4'b0001);
    chk("part_drain_pc", DM_PC, 32'h5000);
    tick();
    chk("part_resolved_stall", Ld_Stall, 0);
    chk("part_resolved_hit", Ld_Hit, 0);
    chk("part_resolved_empty", Empty, 1);
    Ld_Valid = 1'b0;

    // older full, younger partial: stall persists until the partial drains
    DM_Busy = 1'b1;
    do_store(32'h60, 32'h66666666, 4'hF, 32'h5100);
    do_store(32'h60, 32'h12340000, 4'b1100, 32'h5104);
    Ld_Valid = 1'b1; Ld_Addr = 32'h60;
    #1;
    chk("yp_stall", Ld_Stall, 1);
    chk("yp_hit", Ld_Hit, 0);
    DM_Busy = 1'b0;
    tick();
    chk("yp_stall_after1", Ld_Stall, 1);
    tick();
    chk("yp_stall_after2", Ld_Stall, 0);
    chk("yp_hit_after2", Ld_Hit, 0);
    Ld_Valid = 1'b0;

    // older partial, younger full: youngest full word is forwarded
    DM_Busy = 1'b1;
    do_store(32'h80, 32'h0000BB00, 4'b0010, 32'h5200);
    do_store(32'h80, 32'h88888888, 4'hF, 32'h5204);
    Ld_Valid = 1'b1; Ld_Addr = 32'h80;
    #1;
    chk("yf_hit", Ld_Hit, 1);
    chk("yf_data", Ld_Data, 32'h88888888);
    chk("yf_stall", Ld_Stall, 0);
    Ld_Valid = 1'b0; DM_Busy = 1'b0;
    tick();
    tick();
    chk("yf_drained", Empty, 1);

    // reset with three pending stores discards them
    DM_Busy = 1'b1;
    do_store(32'h300, 32'h31, 4'hF, 32'h8000);
    do_store(32'h304, 32'h32, 4'hF, 32'h8004);
    do_store(32'h308, 32'h33, 4'hF, 32'h8008);
    chk("pre_rst_empty", Empty, 0);
    DM_Busy = 1'b0; Reset = 1'b0;
    #1;
    chk("mid_rst_empty", Empty, 1);
    chk("mid_rst_wr", DM_Wr, 0);
    chk("mid_rst_ready", St_Ready, 1);
    chk("mid_rst_dm_a", DM_A, 0);
    tick();
    Reset = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("post_rst_nowr", DM_Wr, 0);
      tick();
    end
    chk("post_rst_empty", Empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
